// File: rtl/read_arbiter_rr.sv
// AXI read-path arbiter: round-robin AR and R grants with
// per-(master, ID) ordering trackers and outstanding counts.
module read_arbiter_rr #(
  parameter int M = 2,
  parameter int S = 2,
  parameter int ID_W = 1,
  parameter int DEPTH = 2,
  parameter int ADDR_WIDTH = 32,
  localparam int MW = $clog2(M),
  localparam int SW = $clog2(S),
  localparam int NID = 2 ** ID_W,
  localparam int CW = $clog2(NID * DEPTH + 1),
  localparam int RW = MW + ID_W
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AR_request_f,
  input  logic [M*ADDR_WIDTH-1:0] AR_addr_f,
  input  logic [M*ID_W-1:0]       AR_id_f,
  input  logic [M-1:0]            AR_hs_f,
  output logic [M-1:0]            AR_grant_f,
  output logic [M*SW-1:0]         AR_sel_f,
  input  logic [S-1:0]            R_request_f,
  input  logic [S*RW-1:0]         R_id_f,
  input  logic [S-1:0]            R_last_f,
  input  logic [S-1:0]            R_hs_f,
  output logic [S-1:0]            R_grant_f,
  output logic [M*CW-1:0]         outstanding_f
);
  localparam int NT = M * NID;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t ar_state, ar_nxt, r_state, r_nxt;
  logic [MW-1:0] ar_owner, ar_owner_nxt, ar_ptr;
  logic [SW-1:0] r_owner, r_owner_nxt, r_ptr;
  logic [RW-1:0] r_trk, r_trk_nxt;

  logic [SW-1:0] mem [NT][DEPTH];
  logic [PW-1:0] wp [NT];
  logic [PW-1:0] rp [NT];
  logic [DW-1:0] cnt [NT];

  logic [SW-1:0] sel [M];
  logic [RW-1:0] ar_key [M];
  logic [RW-1:0] r_key [S];
  logic [M-1:0] ar_elig;
  logic [S-1:0] r_elig;
  logic push, pop;
  logic [NT-1:0] push_hit, pop_hit;
  logic [CW-1:0] outs [M];
  logic unused;

  assign unused = ^AR_addr_f;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int m = 0; m < M; m++) begin
      sel[m] = AR_addr_f[m*ADDR_WIDTH+ADDR_WIDTH-SW +: SW];
      AR_sel_f[m*SW +: SW] = sel[m];
      ar_key[m] = {MW'(m), AR_id_f[m*ID_W +: ID_W]};
      ar_elig[m] = AR_request_f[m]
        && (cnt[ar_key[m]] != DW'(DEPTH));
    end
  end

  // RID is {master, id}, which is exactly the tracker index.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      r_key[s] = '0;
      r_elig[s] = 1'b0;
      if (int'(R_id_f[s*RW+ID_W +: MW]) < M) begin
        r_key[s] = R_id_f[s*RW +: RW];
        r_elig[s] = R_request_f[s]
          && (cnt[r_key[s]] != '0)
          && (mem[r_key[s]][rp[r_key[s]]] == SW'(s));
      end
    end
  end

  always_comb begin
    int ai;
    logic found;
    ar_nxt = ar_state;
    ar_owner_nxt = ar_owner;
    push = 1'b0;
    found = 1'b0;
    ai = 0;
    unique case (ar_state)
      IDLE: begin
        for (int k = 1; k <= M; k++) begin
          ai = (int'(ar_ptr) + k) % M;
          if (!found && ar_elig[ai]) begin
            found = 1'b1;
            ar_owner_nxt = MW'(ai);
            ar_nxt = GRANT;
          end
        end
      end
      GRANT: begin
        if (AR_hs_f[ar_owner]) begin
          push = 1'b1;
          ar_nxt = IDLE;
        end else if (!AR_request_f[ar_owner]) begin
          ar_nxt = IDLE;
        end
      end
      default: ar_nxt = IDLE;
    endcase
  end

  always_comb begin
    int ri;
    logic found;
    r_nxt = r_state;
    r_owner_nxt = r_owner;
    r_trk_nxt = r_trk;
    pop = 1'b0;
    found = 1'b0;
    ri = 0;
    unique case (r_state)
      IDLE: begin
        for (int k = 1; k <= S; k++) begin
          ri = (int'(r_ptr) + k) % S;
          if (!found && r_elig[ri]) begin
            found = 1'b1;
            r_owner_nxt = SW'(ri);
            r_trk_nxt = r_key[ri];
            r_nxt = GRANT;
          end
        end
      end
      GRANT: begin
        if (R_hs_f[r_owner] && R_last_f[r_owner]) begin
          pop = 1'b1;
          r_nxt = IDLE;
        end
      end
      default: r_nxt = IDLE;
    endcase
  end

  always_comb begin
    AR_grant_f = '0;
    R_grant_f = '0;
    if (ar_state == GRANT) AR_grant_f[ar_owner] = 1'b1;
    if (r_state == GRANT) R_grant_f[r_owner] = 1'b1;
    for (int t = 0; t < NT; t++) begin
      push_hit[t] = push && (ar_key[ar_owner] == RW'(t));
      pop_hit[t] = pop && (r_trk == RW'(t));
    end
    for (int m = 0; m < M; m++)
      outstanding_f[m*CW +: CW] = outs[m];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ar_state <= IDLE;
      r_state <= IDLE;
      ar_owner <= '0;
      r_owner <= '0;
      r_trk <= '0;
      ar_ptr <= MW'(M - 1);
      r_ptr <= SW'(S - 1);
    end else begin
      ar_state <= ar_nxt;
      r_state <= r_nxt;
      ar_owner <= ar_owner_nxt;
      r_owner <= r_owner_nxt;
      r_trk <= r_trk_nxt;
      if (push) ar_ptr <= ar_owner;
      if (pop) r_ptr <= r_owner;
    end
  end

  // Push and pop on one tracker cancel in the count only.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NT; t++) begin
      if (clr) begin
        wp[t] <= '0;
        rp[t] <= '0;
        cnt[t] <= '0;
      end else begin
        if (push_hit[t]) begin
          mem[t][wp[t]] <= sel[ar_owner];
          wp[t] <= inc(wp[t]);
        end
        if (pop_hit[t]) rp[t] <= inc(rp[t]);
        if (push_hit[t] && !pop_hit[t])
          cnt[t] <= cnt[t] + 1'b1;
        else if (pop_hit[t] && !push_hit[t])
          cnt[t] <= cnt[t] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int m = 0; m < M; m++) begin
      if (clr) begin
        outs[m] <= '0;
      end else begin
        logic up, dn;
        up = push && (ar_owner == MW'(m));
        dn = pop && (r_trk[RW-1:ID_W] == MW'(m));
        if (up && !dn) outs[m] <= outs[m] + 1'b1;
        else if (dn && !up) outs[m] <= outs[m] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_read_arbiter_rr.sv
// Self-checking bench for read_arbiter_rr: decode table,
// directed ordering/backpressure sequences, random vs model.
module tb_read_arbiter_rr;
  localparam int M = 2;
  localparam int S = 2;
  localparam int ID_W = 1;
  localparam int DEPTH = 2;
  localparam int AW = 32;
  localparam int MW = 1;
  localparam int SW = 1;
  localparam int NID = 2;
  localparam int CW = 3;
  localparam int RW = MW + ID_W;
  localparam int NT = M * NID;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;
  logic [M-1:0] ar_req, ar_hs, ar_grant;
  logic [M*AW-1:0] ar_addr;
  logic [M*ID_W-1:0] ar_id;
  logic [M*SW-1:0] ar_sel;
  logic [S-1:0] r_req, r_last, r_hs, r_grant;
  logic [S*RW-1:0] r_id;
  logic [M*CW-1:0] outs;

  read_arbiter_rr #(
    .M(M), .S(S), .ID_W(ID_W),
    .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .AR_request_f(ar_req),
    .AR_addr_f(ar_addr),
    .AR_id_f(ar_id),
    .AR_hs_f(ar_hs),
    .AR_grant_f(ar_grant),
    .AR_sel_f(ar_sel),
    .R_request_f(r_req),
    .R_id_f(r_id),
    .R_last_f(r_last),
    .R_hs_f(r_hs),
    .R_grant_f(r_grant),
    .outstanding_f(outs)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model: one queue of target slaves per
  // (master, id), plus who currently holds each path.
  int q [NT][$];
  bit ar_busy, r_busy;
  int ar_own, r_own, r_key;
  int ar_rr, r_rr;

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) q[t].delete();
    ar_busy = 0;
    r_busy = 0;
    ar_own = 0;
    r_own = 0;
    r_key = 0;
    ar_rr = M - 1;
    r_rr = S - 1;
  endfunction

  task automatic model_edge();
    int push_k, push_v, pop_k;
    bit nb_ar, nb_r;
    int no_ar, no_r, nk_r;
    if (clr) begin
      model_reset();
      return;
    end
    push_k = -1;
    push_v = 0;
    pop_k = -1;
    nb_ar = ar_busy;
    no_ar = ar_own;
    nb_r = r_busy;
    no_r = r_own;
    nk_r = r_key;
    if (!ar_busy) begin
      for (int k = 1; k <= M; k++) begin
        int m, key;
        m = (ar_rr + k) % M;
        key = m * NID + int'(ar_id[m*ID_W +: ID_W]);
        if (ar_req[m] && q[key].size() < DEPTH) begin
          nb_ar = 1;
          no_ar = m;
          break;
        end
      end
    end else if (ar_hs[ar_own]) begin
      push_k = ar_own * NID
        + int'(ar_id[ar_own*ID_W +: ID_W]);
      push_v = int'(ar_addr[ar_own*AW +: AW] >> (AW - SW));
      ar_rr = ar_own;
      nb_ar = 0;
    end else if (!ar_req[ar_own]) begin
      nb_ar = 0;
    end
    if (!r_busy) begin
      for (int k = 1; k <= S; k++) begin
        int s, rid, mid, key;
        s = (r_rr + k) % S;
        rid = int'(r_id[s*RW +: RW]);
        mid = rid / NID;
        key = mid * NID + rid % NID;
        if (r_req[s] && mid < M) begin
          if (q[key].size() > 0 && q[key][0] == s) begin
            nb_r = 1;
            no_r = s;
            nk_r = key;
            break;
          end
        end
      end
    end else if (r_hs[r_own] && r_last[r_own]) begin
      pop_k = r_key;
      r_rr = r_own;
      nb_r = 0;
    end
    if (pop_k >= 0) void'(q[pop_k].pop_front());
    if (push_k >= 0) q[push_k].push_back(push_v);
    ar_busy = nb_ar;
    ar_own = no_ar;
    r_busy = nb_r;
    r_own = no_r;
    r_key = nk_r;
  endtask

  function automatic logic [M*CW-1:0] exp_outs();
    logic [M*CW-1:0] v;
    v = '0;
    for (int m = 0; m < M; m++) begin
      int n;
      n = 0;
      for (int i = 0; i < NID; i++) n += q[m*NID+i].size();
      v[m*CW +: CW] = CW'(n);
    end
    return v;
  endfunction

  task automatic tick();
    logic [M-1:0] ea;
    logic [S-1:0] er;
    model_edge();
    @(posedge clk);
    #1;
    ea = '0;
    er = '0;
    if (ar_busy) ea[ar_own] = 1'b1;
    if (r_busy) er[r_own] = 1'b1;
    check("model_ar_grant", 64'(ar_grant), 64'(ea));
    check("model_r_grant", 64'(r_grant), 64'(er));
    check("model_outstanding", 64'(outs), 64'(exp_outs()));
  endtask

  task automatic idle_inputs();
    ar_req = '0;
    ar_hs = '0;
    ar_addr = '0;
    ar_id = '0;
    r_req = '0;
    r_last = '0;
    r_hs = '0;
    r_id = '0;
  endtask

  task automatic reset_dut();
    clr = 1'b1;
    idle_inputs();
    tick();
    check("rst_ar_grant", 64'(ar_grant), 64'h0);
    check("rst_r_grant", 64'(r_grant), 64'h0);
    check("rst_outstanding", 64'(outs), 64'h0);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [M*SW-1:0] sel;
  } dec_vec_t;

  dec_vec_t dv [5];

  initial begin
    clr = 1'b1;
    idle_inputs();
    model_reset();

    dv[0] = '{32'h0000_0000, 32'h0000_0000, 2'b00};
    dv[1] = '{32'h8000_0000, 32'h0000_0000, 2'b01};
    dv[2] = '{32'h0000_0000, 32'h8000_0000, 2'b10};
    dv[3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 2'b01};
    dv[4] = '{32'h7FFF_FFFF, 32'hC000_0000, 2'b10};
    for (int i = 0; i < 5; i++) begin
      ar_addr = {dv[i].a1, dv[i].a0};
      #1;
      check($sformatf("decode_%0d", i),
            64'(ar_sel), 64'(dv[i].sel));
    end

    // Two masters, one bubble between grants.
    reset_dut();
    ar_req = 2'b11;
    ar_hs = 2'b11;
    ar_addr = {32'h8000_0000, 32'h0000_0000};
    tick();
    check("t1_grant_m0", 64'(ar_grant), 64'h1);
    check("t1_sel", 64'(ar_sel), 64'h2);
    ar_req = 2'b10;
    tick();
    check("t1_bubble", 64'(ar_grant), 64'h0);
    tick();
    check("t1_grant_m1", 64'(ar_grant), 64'h2);
    ar_req = 2'b00;
    tick();
    check("t1_outstanding", 64'(outs), 64'h9);

    // Full tracker blocks the third request.
    reset_dut();
    ar_req = 2'b01;
    ar_hs = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_full_no_grant", 64'(ar_grant), 64'h0);
    end
    check("t2_out_full", 64'(outs), 64'h2);
    r_req = 2'b01;
    r_last = 2'b01;
    r_hs = 2'b01;
    tick();
    check("t2_r_grant", 64'(r_grant), 64'h1);
    tick();
    check("t2_popped", 64'(outs), 64'h1);
    r_req = 2'b00;
    tick();
    check("t2_third_grant", 64'(ar_grant), 64'h1);
    ar_req = 2'b00;
    tick();
    check("t2_out_refill", 64'(outs), 64'h2);

    // Ordering across slaves for one (master, id).
    reset_dut();
    ar_req = 2'b01;
    ar_hs = 2'b01;
    ar_addr = {32'h0, 32'h8000_0000};
    tick();
    tick();
    ar_addr = '0;
    tick();
    ar_req = 2'b00;
    tick();
    r_req = 2'b01;
    r_last = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_blocked", 64'(r_grant), 64'h0);
    end
    r_req = 2'b11;
    tick();
    check("t3_grant_s1", 64'(r_grant), 64'h2);
    r_hs = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_s1", 64'(r_grant), 64'h2);
    end
    r_last = 2'b11;
    tick();
    check("t3_s1_done", 64'(r_grant), 64'h0);
    r_req = 2'b01;
    r_last = 2'b01;
    r_hs = 2'b00;
    tick();
    check("t3_grant_s0", 64'(r_grant), 64'h1);

    // Backpressure mid-burst, request dropped while stalled.
    reset_dut();
    ar_req = 2'b01;
    ar_hs = 2'b01;
    tick();
    ar_req = 2'b00;
    tick();
    r_req = 2'b01;
    tick();
    check("t4_grant", 64'(r_grant), 64'h1);
    r_hs = 2'b01;
    tick();
    r_hs = 2'b00;
    r_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_stall_hold", 64'(r_grant), 64'h1);
      check("t4_stall_out", 64'(outs), 64'h1);
    end
    r_hs = 2'b01;
    tick();
    tick();
    check("t4_pre_last", 64'(r_grant), 64'h1);
    r_last = 2'b01;
    tick();
    check("t4_done", 64'(r_grant), 64'h0);
    check("t4_out_zero", 64'(outs), 64'h0);

    // Push and pop on the same tracker together.
    reset_dut();
    ar_req = 2'b01;
    ar_hs = 2'b01;
    tick();
    ar_req = 2'b00;
    tick();
    ar_req = 2'b01;
    ar_addr = {32'h0, 32'h8000_0000};
    r_req = 2'b01;
    r_hs = 2'b01;
    r_last = 2'b01;
    tick();
    check("t5_ar_grant", 64'(ar_grant), 64'h1);
    check("t5_r_grant", 64'(r_grant), 64'h1);
    ar_req = 2'b00;
    r_req = 2'b00;
    tick();
    check("t5_count_same", 64'(outs), 64'h1);
    r_req = 2'b01;
    r_hs = 2'b00;
    tick();
    check("t5_old_head_gone", 64'(r_grant), 64'h0);
    r_req = 2'b10;
    tick();
    check("t5_new_head", 64'(r_grant), 64'h2);

    // Clear in the middle of an R burst.
    reset_dut();
    ar_req = 2'b01;
    ar_hs = 2'b01;
    tick();
    ar_req = 2'b00;
    tick();
    r_req = 2'b01;
    r_hs = 2'b01;
    tick();
    tick();
    check("t6_mid_burst", 64'(r_grant), 64'h1);
    clr = 1'b1;
    tick();
    check("t6_clr_ar", 64'(ar_grant), 64'h0);
    check("t6_clr_r", 64'(r_grant), 64'h0);
    check("t6_clr_out", 64'(outs), 64'h0);
    clr = 1'b0;
    idle_inputs();
    ar_req = 2'b11;
    tick();
    check("t6_first_m0", 64'(ar_grant), 64'h1);

    // Random traffic against the model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < M; m++) begin
        ar_req[m] = ($urandom_range(0, 3) != 0);
        ar_hs[m] = $urandom_range(0, 1);
        ar_addr[m*AW +: AW] = $urandom;
        if (!(ar_busy && ar_own == m))
          ar_id[m*ID_W +: ID_W] = ID_W'($urandom);
      end
      for (int s = 0; s < S; s++) begin
        r_req[s] = ($urandom_range(0, 2) != 0);
        r_hs[s] = ($urandom_range(0, 3) != 0);
        r_last[s] = ($urandom_range(0, 2) == 0);
        r_id[s*RW +: RW] = RW'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/read_arbiter_rr.md
Name: read_arbiter_rr

Overview:
Parametrised next-generation AXI read-path arbiter for the interconnect.
- Round-robin arbitration of M masters onto the read-address (AR) path, with a one-cycle grant decision that skips idle masters.
- Per-(master, ID) ordering trackers of configurable depth; each entry records the target slave.
- Round-robin arbitration of S slaves onto the read-data (R) path. A burst is admitted only when it is the oldest outstanding for its (master, ID), and is held until RLAST is accepted.
- Per-master outstanding counts are reported.

Parameters:
M, 2, number of masters (>=2)
S, 2, number of slaves (power of two, >=2)
ID_W, 1, per-master transaction ID width; NID = 2**ID_W trackers per master
DEPTH, 2, entries per ordering tracker (>=1)
ADDR_WIDTH, 32, address width
Derived: MW = clog2(M), SW = clog2(S), CW = clog2(NID*DEPTH+1)

Ports:
clk  in  1  clock
clr  in  1  reset, synchronous, active-high
AR_request_f  in  M  per-master AR request (ARVALID)
AR_addr_f  in  M*ADDR_WIDTH  per-master ARADDR
AR_id_f  in  M*ID_W  per-master ARID
AR_hs_f  in  M  per-master AR handshake completed this cycle
AR_grant_f  out  M  one-hot AR grant
AR_sel_f  out  M*SW  decoded slave index per master
R_request_f  in  S  per-slave R request (RVALID)
R_id_f  in  S*(MW+ID_W)  per-slave RID = {master_id, trans_id}
R_last_f  in  S  per-slave RLAST
R_hs_f  in  S  per-slave R beat accepted this cycle
R_grant_f  out  S  one-hot R grant
outstanding_f  out  M*CW  per-master count of tracked, unfinished reads

Behaviour:
Reset
- While clr=1 at a rising edge:
  - all trackers are emptied;
  - both FSMs go to IDLE;
  - all grants and outstanding counts are 0;
  - round-robin pointers are set to M-1 and S-1, so master 0 and slave 0 have first priority.
- clr mid-burst drops the grant on the next edge. Entries in flight are discarded.

Decode
- AR_sel[m] = AR_addr[m][ADDR_WIDTH-1 -: SW]. Purely combinational.

AR FSM: states IDLE, GRANT
- Master m is eligible when AR_request[m]=1 and tracker[m][AR_id[m]] is not full.
- IDLE:
  - Search cyclically from ar_ptr+1 for the first eligible master.
  - If one is found, latch it as ar_owner and go to GRANT. The grant is asserted the following cycle (1-cycle latency).
- GRANT:
  - AR_grant[ar_owner]=1.
  - If AR_hs[ar_owner]=1: push AR_sel[ar_owner] into tracker[ar_owner][AR_id[ar_owner]], set ar_ptr = ar_owner, go to IDLE.
  - Else if AR_request[ar_owner]=0: abort to IDLE with no push and ar_ptr unchanged.
- There is one bubble cycle between consecutive AR grants.
- AR_hs from a non-granted master is ignored.

R FSM: states IDLE, GRANT
- Slave s is eligible when all of the following hold:
  - R_request[s]=1;
  - master_id < M;
  - tracker[master_id][trans_id] is not empty;
  - its head equals s.
- IDLE:
  - Cyclic search from r_ptr+1. If an eligible slave is found, latch r_owner and go to GRANT.
- GRANT:
  - R_grant[r_owner]=1 and is held across beats.
  - On R_hs[r_owner] & R_last[r_owner]: pop that tracker, set r_ptr = r_owner, go to IDLE.
  - Beats without last keep GRANT.
  - A request deassert does not end the burst.

Trackers
- Each tracker is a circular FIFO with DEPTH entries of SW bits; pointers wrap modulo DEPTH.
- Full means count == DEPTH.
- A push and a pop on the same tracker in the same cycle are both performed, and the count is unchanged. This applies even when the tracker is full, since the pop frees a slot.
- A push is never issued to a full tracker; a pop is never issued to an empty one.

outstanding[m]
- Sum of tracker counts for master m, registered.
- +1 on push, -1 on pop, unchanged if both occur.

Test Plan:
- Reset, then M=2, both masters request AR (addr 0x0000_0000 and 0x8000_0000, id 0) with hs the cycle after grant -> grant master 0 at cycle 1, master 1 at cycle 3; AR_sel = 0 and 1; outstanding = 1,1.
- DEPTH=2: master 0 issues 3 AR with id 0 and no R traffic -> the first two are granted; the third never gets a grant; outstanding[0]=2. One R burst completes -> the third is granted.
- Ordering: master 0 id 0 sends to slave 1, then to slave 0. Slave 0 responds first -> R_grant stays 0 until slave 1's burst (4 beats, last on beat 4) completes; then slave 0 is granted.
- 4-beat burst with R_hs deasserted on beat 2 for 2 cycles -> R_grant[owner] held throughout; tracker popped only on the last-beat handshake.
- Simultaneous push and pop on the same tracker (count 1) -> count stays 1; the head advances to the new entry.
- clr=1 asserted during an R burst -> next cycle all grants are 0 and outstanding is 0; after release, master 0 is granted first.
